// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I sequencer: owns the PC, walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath controls and counts retirements.
module multi_cycle_ctrl #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC     = XLEN'(32'h28),
  parameter int unsigned      CNT_W        = 16,
  parameter int unsigned      MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic [XLEN-1:0]  branch,
  input  logic [XLEN-1:0]  jTarget,
  input  logic             mem_ack,
  output logic [XLEN-1:0]  pc,
  output logic             if_en,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             Mem2Reg,
  output logic             link_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_JAL} cls_e;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                alusrc_q, alusrc_d;
  logic [2:0]          op_q, op_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        f7b;
  logic        dec_ok, dec_ecall, dec_src;
  cls_e        dec_cls;
  logic [2:0]  dec_op;
  logic        taken, mem_timeout, retire;
  logic [XLEN-1:0] pc_inc;
  logic        unused_ins;

  assign opc        = ins[6:0];
  assign f3         = ins[14:12];
  assign f7b        = ins[30];
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  always_comb begin
    dec_ok    = 1'b1;
    dec_ecall = 1'b0;
    dec_cls   = C_ALU;
    dec_src   = 1'b0;
    dec_op    = OP_ADD;
    case (opc)
      7'h33: case (f3)
        3'b000:  dec_op = f7b ? OP_SUB : OP_ADD;
        3'b111:  dec_op = OP_AND;
        3'b110:  dec_op = OP_OR;
        3'b010:  dec_op = OP_SLT;
        default: dec_ok = 1'b0;
      endcase
      7'h13: begin
        dec_src = 1'b1;
        case (f3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_ok = 1'b0;
        endcase
      end
      7'h03: begin dec_cls = C_LW; dec_src = 1'b1; dec_ok = (f3 == 3'b010); end
      7'h23: begin dec_cls = C_SW; dec_src = 1'b1; dec_ok = (f3 == 3'b010); end
      7'h63: begin
        dec_op = OP_SUB;
        case (f3)
          3'b000:  dec_cls = C_BEQ;
          3'b001:  dec_cls = C_BNE;
          default: dec_ok  = 1'b0;
        endcase
      end
      7'h6F:   dec_cls   = C_JAL;
      7'h73:   dec_ecall = 1'b1;
      default: dec_ok    = 1'b0;
    endcase
  end

  assign pc_inc      = pc_q + XLEN'(4);
  assign taken       = ((cls_q == C_BEQ) && zero) || ((cls_q == C_BNE) && !zero);
  // A zero limit disables the memory-wait timeout entirely.
  assign mem_timeout = (MEM_WAIT_MAX != 0) && (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    alusrc_d  = alusrc_q;
    op_d      = op_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_ecall) begin
          state_d = S_HALT;
        end else if (!dec_ok) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cls_d    = dec_cls;
          alusrc_d = dec_src;
          op_d     = dec_op;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: case (cls_q)
        C_LW, C_SW: begin
          wait_d  = '0;
          state_d = S_MEM;
        end
        C_BEQ, C_BNE: begin
          retire = 1'b1;
          pc_d   = taken ? branch : pc_inc;
        end
        default: state_d = S_WB;
      endcase
      S_MEM: begin
        if (mem_ack) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            retire = 1'b1;
            pc_d   = pc_inc;
          end
        end else if (mem_timeout) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        retire = 1'b1;
        pc_d   = (cls_q == C_JAL) ? jTarget : pc_inc;
      end
      S_HALT:  ;
      default: state_d = S_HALT;
    endcase
    if (retire) begin
      instret_d = instret_q + 1'b1;
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      alusrc_q  <= 1'b0;
      op_q      <= OP_ADD;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      alusrc_q  <= alusrc_d;
      op_q      <= op_d;
    end
  end

  assign pc       = pc_q;
  assign state    = state_q;
  assign instret  = instret_q;
  assign illegal  = illegal_q;
  assign ALUSrc   = alusrc_q;
  assign op       = op_q;
  assign if_en    = (state_q == S_FETCH);
  assign RegWrite = (state_q == S_WB);
  assign mem_rd   = (state_q == S_MEM) && (cls_q == C_LW);
  assign mem_wr   = (state_q == S_MEM) && (cls_q == C_SW);
  assign Mem2Reg  = (state_q == S_WB) && (cls_q == C_LW);
  assign link_sel = (state_q == S_WB) && (cls_q == C_JAL);
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-instruction expectations are queued at issue
// and compared against what the sequencer did once the instruction finishes.
module tb_multi_cycle_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam int MW    = 15;

  logic             clk, rst_n, run, zero, mem_ack;
  logic [31:0]      ins;
  logic [XLEN-1:0]  branch, jTarget, pc;
  logic             if_en, RegWrite, ALUSrc, mem_rd, mem_wr, Mem2Reg, link_sel;
  logic             halted, illegal;
  logic [2:0]       op, state;
  logic [CNT_W-1:0] instret;

  multi_cycle_ctrl #(.XLEN(XLEN), .RESET_PC(32'h28), .CNT_W(CNT_W), .MEM_WAIT_MAX(MW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ins(ins), .zero(zero),
    .branch(branch), .jTarget(jTarget), .mem_ack(mem_ack),
    .pc(pc), .if_en(if_en), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .Mem2Reg(Mem2Reg), .link_sel(link_sel),
    .state(state), .halted(halted), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    int          ret;
    int          cyc;
    int          rw;
    int          mem;
    int          m2r;
    int          lk;
    logic        src;
    logic [2:0]  op;
    logic        chk;
    logic [2:0]  st;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_ret = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input string tag);
    for (int i = 0; i < 20 && state !== 3'd1; i++) tick();
    check_val({tag, " reach_fetch"}, {29'd0, state}, 32'd1);
  endtask

  task automatic issue(input string tag, input logic [31:0] w, input logic z,
                       input int ack_dly, input bit drop_run, input bit retires,
                       input logic [31:0] e_pc, input int e_cyc, input int e_rw,
                       input int e_mem, input int e_m2r, input int e_lk,
                       input logic e_src, input logic [2:0] e_op, input logic e_chk,
                       input logic [2:0] e_st, input logic e_ill);
    exp_t e, x;
    int cyc, rw, mc, m2r, lk, ifc, mcount;
    logic osrc;
    logic [2:0] oop;
    bit done;
    wait_fetch(tag);
    e.tag = tag; e.pc = e_pc; e.cyc = e_cyc; e.rw = e_rw; e.mem = e_mem;
    e.m2r = e_m2r; e.lk = e_lk; e.src = e_src; e.op = e_op; e.chk = e_chk;
    e.st = e_st; e.ill = e_ill;
    e.ret = (model_ret + int'(retires)) % (1 << CNT_W);
    model_ret += int'(retires);
    sb.push_back(e);

    ins = w; zero = z; mem_ack = 1'b0;
    cyc = 1; ifc = int'(if_en); rw = 0; mc = 0; m2r = 0; lk = 0; mcount = 0;
    osrc = 1'b0; oop = 3'b010; done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (state == 3'd1 || state == 3'd0 || state == 3'd6) begin
        done = 1'b1;
        break;
      end
      cyc++;
      ifc += int'(if_en);
      rw  += int'(RegWrite);
      mc  += int'(mem_rd | mem_wr);
      m2r += int'(RegWrite & Mem2Reg);
      lk  += int'(RegWrite & link_sel);
      if (state == 3'd3) begin osrc = ALUSrc; oop = op; end
      if (drop_run && state == 3'd2) run = 1'b0;
      if (state == 3'd4) begin
        mcount++;
        mem_ack = (ack_dly >= 0) && (mcount > ack_dly);
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;

    x = sb.pop_front();
    check_val({x.tag, " done"},    {31'd0, done}, 32'd1);
    check_val({x.tag, " pc"},      pc, x.pc);
    check_val({x.tag, " instret"}, {30'd0, instret}, x.ret);
    check_val({x.tag, " cycles"},  cyc, x.cyc);
    check_val({x.tag, " if_en"},   ifc, 1);
    check_val({x.tag, " regwr"},   rw, x.rw);
    check_val({x.tag, " memstb"},  mc, x.mem);
    check_val({x.tag, " mem2reg"}, m2r, x.m2r);
    check_val({x.tag, " link"},    lk, x.lk);
    check_val({x.tag, " state"},   {29'd0, state}, {29'd0, x.st});
    check_val({x.tag, " illegal"}, {31'd0, illegal}, {31'd0, x.ill});
    check_val({x.tag, " halted"},  {31'd0, halted}, {31'd0, (x.st == 3'd6)});
    if (x.chk) begin
      check_val({x.tag, " alusrc"}, {31'd0, osrc}, {31'd0, x.src});
      check_val({x.tag, " op"},     {29'd0, oop}, {29'd0, x.op});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; run = 1'b0; ins = 32'h0; zero = 1'b0; mem_ack = 1'b0;
    branch = 32'h40; jTarget = 32'h38;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst pc",      pc, 32'h28);
    check_val("rst state",   {29'd0, state}, 32'd0);
    check_val("rst instret", {30'd0, instret}, 32'd0);
    check_val("rst regwr",   {31'd0, RegWrite}, 32'd0);
    check_val("rst if_en",   {31'd0, if_en}, 32'd0);
    check_val("rst op",      {29'd0, op}, 32'd2);
    check_val("rst halted",  {31'd0, halted}, 32'd0);
    check_val("rst illegal", {31'd0, illegal}, 32'd0);
    #9 rst_n = 1'b1;
    tick(); tick();
    check_val("idle hold", {29'd0, state}, 32'd0);
    run = 1'b1;

    //    tag       word          z  ack drop ret  pc           cyc rw mem m2r lk src op     chk  st    ill
    issue("add0",  32'h007302B3, 0, 0,  0,   1,   32'h2C,      4,  1, 0,  0,  0, 0, 3'b010, 1, 3'd1, 0);
    issue("sub0",  32'h407302B3, 0, 0,  0,   1,   32'h30,      4,  1, 0,  0,  0, 0, 3'b110, 1, 3'd1, 0);

    wait_fetch("midrst");
    ins = 32'h007302B3;
    tick(); tick();
    check_val("midrst exec",  {29'd0, state}, 32'd3);
    check_val("midrst pc0",   pc, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst pc",      pc, 32'h28);
    check_val("midrst state",   {29'd0, state}, 32'd0);
    check_val("midrst instret", {30'd0, instret}, 32'd0);
    check_val("midrst regwr",   {31'd0, RegWrite}, 32'd0);
    model_ret = 0;
    #3 rst_n = 1'b1;

    issue("andi",  32'h00537293, 0, 0,  0,   1,   32'h2C,      4,  1, 0,  0,  0, 1, 3'b000, 1, 3'd1, 0);
    issue("beqT",  32'h00000063, 1, 0,  0,   1,   32'h40,      3,  0, 0,  0,  0, 0, 3'b110, 1, 3'd1, 0);
    issue("beqN",  32'h00000063, 0, 0,  0,   1,   32'h44,      3,  0, 0,  0,  0, 0, 3'b110, 1, 3'd1, 0);
    issue("bneT",  32'h00001063, 0, 0,  0,   1,   32'h40,      3,  0, 0,  0,  0, 0, 3'b110, 1, 3'd1, 0);
    issue("lw3",   32'h00032283, 0, 3,  0,   1,   32'h44,      8,  1, 4,  1,  0, 1, 3'b010, 1, 3'd1, 0);
    issue("sw0",   32'h00532023, 0, 0,  0,   1,   32'h48,      4,  0, 1,  0,  0, 1, 3'b010, 1, 3'd1, 0);
    issue("slt",   32'h007322B3, 0, 0,  0,   1,   32'h4C,      4,  1, 0,  0,  0, 0, 3'b111, 1, 3'd1, 0);
    issue("ori",   32'h00536293, 0, 0,  0,   1,   32'h50,      4,  1, 0,  0,  0, 1, 3'b001, 1, 3'd1, 0);
    issue("jal",   32'h0100006F, 0, 0,  0,   1,   32'h38,      4,  1, 0,  0,  1, 0, 3'b010, 0, 3'd1, 0);
    issue("drop",  32'h007302B3, 0, 0,  1,   1,   32'h3C,      4,  1, 0,  0,  0, 0, 3'b010, 1, 3'd0, 0);

    tick(); tick(); tick();
    check_val("idle stay",  {29'd0, state}, 32'd0);
    check_val("idle if_en", {31'd0, if_en}, 32'd0);
    run = 1'b1;

    issue("swto",  32'h00532023, 0, -1, 0,   0,   32'h3C,      18, 0, 15, 0,  0, 1, 3'b010, 1, 3'd6, 1);
    check_val("swto mem_wr", {31'd0, mem_wr}, 32'd0);
    mem_ack = 1'b1;
    tick(); tick(); tick();
    mem_ack = 1'b0;
    check_val("halt absorb", {29'd0, state}, 32'd6);
    check_val("halt pc",     pc, 32'h3C);

    rst_n = 1'b0; #3 rst_n = 1'b1;
    model_ret = 0;
    issue("jal2",  32'h0100006F, 0, 0,  0,   1,   32'h38,      4,  1, 0,  0,  1, 0, 3'b010, 0, 3'd1, 0);
    issue("ill",   32'hFFFFFFFF, 0, 0,  0,   0,   32'h38,      2,  0, 0,  0,  0, 0, 3'b010, 0, 3'd6, 1);

    rst_n = 1'b0; #3 rst_n = 1'b1;
    model_ret = 0;
    jTarget = 32'hFFFF_FFFC;
    issue("jalw",  32'h0100006F, 0, 0,  0,   1,   32'hFFFFFFFC, 4, 1, 0,  0,  1, 0, 3'b010, 0, 3'd1, 0);
    issue("pcwrap",32'h007302B3, 0, 0,  0,   1,   32'h0,       4,  1, 0,  0,  0, 0, 3'b010, 1, 3'd1, 0);
    issue("add3",  32'h007302B3, 0, 0,  0,   1,   32'h4,       4,  1, 0,  0,  0, 0, 3'b010, 1, 3'd1, 0);
    issue("add4",  32'h007302B3, 0, 0,  0,   1,   32'h8,       4,  1, 0,  0,  0, 0, 3'b010, 1, 3'd1, 0);
    issue("add5",  32'h007302B3, 0, 0,  0,   1,   32'hC,       4,  1, 0,  0,  0, 0, 3'b010, 1, 3'd1, 0);
    check_val("instret wrap", {30'd0, instret}, 32'd1);
    issue("ecall", 32'h00000073, 0, 0,  0,   0,   32'hC,       2,  0, 0,  0,  0, 0, 3'b010, 0, 3'd6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Parametrised multi-cycle sequencer for the RV32I datapath (instruction fetch, decode, execute blocks).
- Replaces hand-sequenced control in benches: owns the PC, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and decodes opcode/funct into datapath controls.
- Resolves beq/bne/jal.
- Handshakes with data memory.
- Halts on ecall or an illegal opcode.
- Counts retired instructions.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h28, PC value after reset
CNT_W, 16, width of retired-instruction counter
MEM_WAIT_MAX, 15, max MEM-state cycles waiting for mem_ack before error halt (0 disables timeout)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; sequencer leaves IDLE/continues while high
ins  in  32  instruction from fetch stage, valid from cycle after if_en
zero  in  1  ALU zero flag, valid in EXEC
branch  in  XLEN  branch target from decode
jTarget  in  XLEN  jal target from decode
mem_ack  in  1  data memory completion, sampled in MEM
pc  out  XLEN  current instruction address
if_en  out  1  one-cycle fetch strobe (drives fetch clock enable)
RegWrite  out  1  register-file write, asserted only in WB
ALUSrc  out  1  1 = immediate operand
op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
mem_rd  out  1  load request, held in MEM until ack
mem_wr  out  1  store request, held in MEM until ack
Mem2Reg  out  1  WB data from memory
link_sel  out  1  WB data = pc+4 (jal)
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
halted  out  1  high in HALT
illegal  out  1  sticky; unsupported opcode, funct or mem timeout
instret  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - All strobes/controls 0, op=010.
  - halted=0, illegal=0, instret=0.
  - Wait counter cleared.
  - Reset mid-instruction aborts with no write and no PC update.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: if_en=1 for exactly this cycle -> DECODE.
- DECODE: latch ins[6:0], funct3, funct7[5]; set ALUSrc/op, held until the instruction retires.
  - 0x33 R-type: ALUSrc=0. funct3/funct7: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
  - 0x13 I-ALU: ALUSrc=1. funct3: 000 add, 111 and, 110 or, 010 slt.
  - 0x03 lw (funct3 010): ALUSrc=1, op=add.
  - 0x23 sw (funct3 010): ALUSrc=1, op=add.
  - 0x63 beq/bne (funct3 000/001): ALUSrc=0, op=sub.
  - 0x6F jal: op=add.
  - 0x73 ecall -> HALT with no retire.
  - Anything else -> illegal=1, HALT.
  - Otherwise -> EXEC.
- EXEC:
  - R/I/jal -> WB.
  - lw/sw -> MEM.
  - Branch retires here: taken = (beq & zero) | (bne & ~zero). pc <= taken ? branch : pc+4. instret++. Then FETCH if run=1, else IDLE.
- MEM: mem_rd (lw) or mem_wr (sw) held high.
  - mem_ack=1: lw -> WB; sw retires (pc+=4, instret++) -> FETCH/IDLE.
  - Timeout: wait counter reaches MEM_WAIT_MAX without ack -> illegal=1, HALT, strobes drop.
  - mem_ack outside MEM is ignored.
- WB: RegWrite=1 for exactly this cycle; Mem2Reg=1 for lw; link_sel=1 for jal. Retire:
  - jal: pc <= jTarget.
  - Others: pc <= pc+4.
  - instret++.
  - Then FETCH if run=1, else IDLE.
- run deassert mid-instruction: the current instruction completes, then IDLE.
- HALT: absorbing until reset; all strobes 0; pc holds the halting instruction's address.
- PC arithmetic modulo 2^XLEN; pc+4 wraps.
- Cycles per instruction:
  - Branch 3.
  - R/I/jal 4.
  - sw 4+w.
  - lw 5+w.
  - w = cycles mem_ack stays low in MEM.
- All outputs registered or decoded from registered state only; no combinational path from ins to if_en.

Test Plan:
- Reset with rst_n low mid-EXEC at pc=0x30 -> pc=0x28, state=0, instret=0, RegWrite=0 immediately, before any clk edge.
- run=1, ins=add x5,x6,x7 (0x007302B3) at 0x28 -> if_en@c1, DECODE c2 (ALUSrc=0, op=010), RegWrite only @c4, pc=0x2C, instret=1.
- beq with zero=1, branch=0x40 -> pc=0x40 after 3 cycles, no RegWrite. Same with zero=0 -> pc+4. bne with zero=0, branch=0x40 -> pc=0x40.
- lw with mem_ack delayed 3 cycles -> mem_rd high exactly 4 cycles, then WB with Mem2Reg=1, RegWrite=1; total 8 cycles.
- sw with mem_ack never asserted, MEM_WAIT_MAX=15 -> HALT after 15 MEM cycles, illegal=1, mem_wr=0, instret unchanged.
- jal (0x0100006F), jTarget=0x38 -> link_sel=1 with RegWrite in WB, pc=0x38. Next ins 0xFFFFFFFF -> illegal=1, halted=1. Instret wrap: CNT_W=2, 5 retired instructions -> instret=1.
